// File: rtl/term_dsp_pkg.sv
// Shared constants for the N-terminal DSP loopback block: group indices,
// group widths and flat-bus offsets, latency-field and counter widths.
package term_dsp_pkg;

  localparam int NUM_GROUPS = 5;

  localparam int G0 = 0;  // N1END  -> S1BEG
  localparam int G1 = 1;  // N2MID  -> S2BEG
  localparam int G2 = 2;  // N2END  -> S2BEGb
  localparam int G3 = 3;  // N4END  -> S4BEG
  localparam int G4 = 4;  // NN4END -> SS4BEG

  localparam int W_G0 = 4;
  localparam int W_G1 = 8;
  localparam int W_G2 = 8;
  localparam int W_G3 = 16;
  localparam int W_G4 = 16;

  // Bit offsets of each group inside the concatenated input bus
  localparam int OFF_G0  = 0;
  localparam int OFF_G1  = OFF_G0 + W_G0;
  localparam int OFF_G2  = OFF_G1 + W_G1;
  localparam int OFF_G3  = OFF_G2 + W_G2;
  localparam int OFF_G4  = OFF_G3 + W_G3;
  localparam int TOTAL_W = OFF_G4 + W_G4;

  localparam int LAT_W   = 2;
  localparam int CNT_W   = 16;
  localparam int CLR_BIT = 31;

  // Tap encodings; 2 and 3 both select the second register stage
  typedef enum logic [LAT_W-1:0] {
    LAT_COMB = 2'd0,
    LAT_ONE  = 2'd1,
    LAT_TWO  = 2'd2,
    LAT_TWO3 = 2'd3
  } lat_e;

endpackage

// File: rtl/term_delay_line.sv
// Two-stage free-running delay line with a latency-selected output tap.
// The stages shift every cycle regardless of the tap, so changing the
// tap never flushes data or inserts a bubble.
module term_delay_line
  import term_dsp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             UserCLK,
  input  logic             rst_n,
  input  logic [LAT_W-1:0] lat,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  // Shift register: always advances by one stage per clock
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= din;
      stage2 <= stage1;
    end
  end

  // Output tap selection: live input, first stage, or second stage
  always_comb begin
    dout = din;
    case (lat)
      LAT_COMB: dout = din;
      LAT_ONE:  dout = stage1;
      LAT_TWO:  dout = stage2;
      default:  dout = stage2;
    endcase
  end

endmodule

// File: rtl/n_term_dsp_loopback.sv
// N-terminal loopback: each incoming wire group is returned index-reversed
// through a per-group configurable delay (0, 1 or 2 cycles).
// Optional feature macro TERM_ACT_CNT_EN adds per-group saturating
// activity counters readable through act_sel/act_cnt; without it act_cnt
// is tied to zero and no counter state exists.
module n_term_dsp_loopback
  import term_dsp_pkg::*;
(
  input  logic        UserCLK,
  input  logic        rst_n,
  input  logic [3:0]  N1END,
  input  logic [7:0]  N2MID,
  input  logic [7:0]  N2END,
  input  logic [15:0] N4END,
  input  logic [15:0] NN4END,
  output logic [3:0]  S1BEG,
  output logic [7:0]  S2BEG,
  output logic [7:0]  S2BEGb,
  output logic [15:0] S4BEG,
  output logic [15:0] SS4BEG,
  input  logic [31:0] FrameData,
  input  logic        FrameStrobe,
  input  logic [2:0]  act_sel,
  output logic [15:0] act_cnt
);

  logic [LAT_W-1:0] lat [NUM_GROUPS];

  // Latency configuration: every group's field is rewritten on a strobe
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_GROUPS; g++) lat[g] <= '0;
    end else if (FrameStrobe) begin
      for (int g = 0; g < NUM_GROUPS; g++) lat[g] <= FrameData[2*g +: LAT_W];
    end else begin
      for (int g = 0; g < NUM_GROUPS; g++) lat[g] <= lat[g];
    end
  end

  term_delay_line #(.WIDTH(W_G0)) u_dl_g0 (
    .UserCLK(UserCLK), .rst_n(rst_n), .lat(lat[G0]),
    .din({<<{N1END}}), .dout(S1BEG));

  term_delay_line #(.WIDTH(W_G1)) u_dl_g1 (
    .UserCLK(UserCLK), .rst_n(rst_n), .lat(lat[G1]),
    .din({<<{N2MID}}), .dout(S2BEG));

  term_delay_line #(.WIDTH(W_G2)) u_dl_g2 (
    .UserCLK(UserCLK), .rst_n(rst_n), .lat(lat[G2]),
    .din({<<{N2END}}), .dout(S2BEGb));

  term_delay_line #(.WIDTH(W_G3)) u_dl_g3 (
    .UserCLK(UserCLK), .rst_n(rst_n), .lat(lat[G3]),
    .din({<<{N4END}}), .dout(S4BEG));

  term_delay_line #(.WIDTH(W_G4)) u_dl_g4 (
    .UserCLK(UserCLK), .rst_n(rst_n), .lat(lat[G4]),
    .din({<<{NN4END}}), .dout(SS4BEG));

`ifdef TERM_ACT_CNT_EN

  logic [TOTAL_W-1:0]    all_in;
  logic [TOTAL_W-1:0]    prev_in;
  logic [TOTAL_W-1:0]    diff;
  logic [NUM_GROUPS-1:0] grp_chg;
  logic [CNT_W-1:0]      cnt [NUM_GROUPS];
  logic                  cnt_clr;
  logic                  unused_cfg;

  assign all_in     = {NN4END, N4END, N2END, N2MID, N1END};
  assign diff       = all_in ^ prev_in;
  assign cnt_clr    = FrameStrobe & FrameData[CLR_BIT];
  assign unused_cfg = &{1'b0, FrameData[30:10]};

  // Per-group change detect against last cycle's input sample
  always_comb begin
    grp_chg     = '0;
    grp_chg[G0] = |diff[OFF_G1-1:OFF_G0];
    grp_chg[G1] = |diff[OFF_G2-1:OFF_G1];
    grp_chg[G2] = |diff[OFF_G3-1:OFF_G2];
    grp_chg[G3] = |diff[OFF_G4-1:OFF_G3];
    grp_chg[G4] = |diff[TOTAL_W-1:OFF_G4];
  end

  // Previous-input sample register
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) prev_in <= '0;
    else        prev_in <= all_in;
  end

  // Saturating activity counters; a clear strobe wins over an increment
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_GROUPS; g++) cnt[g] <= '0;
    end else begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (cnt_clr)                          cnt[g] <= '0;
        else if (grp_chg[g] && (~&cnt[g]))    cnt[g] <= cnt[g] + 16'd1;
        else                                  cnt[g] <= cnt[g];
      end
    end
  end

  // Counter read mux; unused selects read zero
  always_comb begin
    act_cnt = 16'h0000;
    case (act_sel)
      3'd0:    act_cnt = cnt[G0];
      3'd1:    act_cnt = cnt[G1];
      3'd2:    act_cnt = cnt[G2];
      3'd3:    act_cnt = cnt[G3];
      3'd4:    act_cnt = cnt[G4];
      default: act_cnt = 16'h0000;
    endcase
  end

`else

  logic unused_cfg;

  assign act_cnt    = 16'h0000;
  assign unused_cfg = &{1'b0, FrameData[31:10], act_sel};

`endif

endmodule

// File: tb/tb_n_term_dsp_loopback.sv
// Scoreboard bench for n_term_dsp_loopback: the driver pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares.
// Counter checks are only meaningful when TERM_ACT_CNT_EN is defined.
module tb_n_term_dsp_loopback;

  logic        UserCLK;
  logic        rst_n;
  logic [3:0]  N1END;
  logic [7:0]  N2MID;
  logic [7:0]  N2END;
  logic [15:0] N4END;
  logic [15:0] NN4END;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG;
  logic [7:0]  S2BEGb;
  logic [15:0] S4BEG;
  logic [15:0] SS4BEG;
  logic [31:0] FrameData;
  logic        FrameStrobe;
  logic [2:0]  act_sel;
  logic [15:0] act_cnt;

  n_term_dsp_loopback dut (
    .UserCLK(UserCLK), .rst_n(rst_n),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .act_sel(act_sel), .act_cnt(act_cnt)
  );

  localparam int SEL_S1 = 0, SEL_S2 = 1, SEL_S2B = 2, SEL_S4 = 3, SEL_SS4 = 4, SEL_ACT = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic expect_out(input string name, input int sel, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every pending expectation against the outputs on the falling edge
  always @(negedge UserCLK) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [15:0] got;
      e = exp_q.pop_front();
      case (e.sel)
        SEL_S1:  got = {12'h000, S1BEG};
        SEL_S2:  got = {8'h00, S2BEG};
        SEL_S2B: got = {8'h00, S2BEGb};
        SEL_S4:  got = S4BEG;
        SEL_SS4: got = SS4BEG;
        default: got = act_cnt;
      endcase
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; N1END = '0; N2MID = '0; N2END = '0; N4END = '0; NN4END = '0;
    FrameData = '0; FrameStrobe = 1'b0; act_sel = 3'd0;

    // Reset: combinational reversal, counter reads zero
    step();
    N1END = 4'b0001; N2MID = 8'h01; N2END = 8'h03; N4END = 16'h0001; NN4END = 16'h00F0;
    expect_out("rst_s1", SEL_S1, 16'h0008);
    expect_out("rst_s2", SEL_S2, 16'h0080);
    expect_out("rst_s2b", SEL_S2B, 16'h00C0);
    expect_out("rst_s4", SEL_S4, 16'h8000);
    expect_out("rst_ss4", SEL_SS4, 16'h0F00);
    expect_out("rst_act", SEL_ACT, 16'h0000);

    // Release reset, still lat=0
    step();
    rst_n = 1'b1; N1END = 4'b0011; N2MID = 8'h00;
    expect_out("rel_s1", SEL_S1, 16'h000C);
    expect_out("rel_s2", SEL_S2, 16'h0000);
    step();

    // lat[1]=2: N2MID pulse appears two edges later
    step();
    FrameData = 32'h0000_0008; FrameStrobe = 1'b1;
    expect_out("cfg_s2", SEL_S2, 16'h0000);
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0; N2MID = 8'h01; N1END = 4'b0001;
    expect_out("l2_t0_s2", SEL_S2, 16'h0000);
    expect_out("l2_t0_s1", SEL_S1, 16'h0008);
    step();
    N2MID = 8'h00;
    expect_out("l2_t1_s2", SEL_S2, 16'h0000);
    step();
    N1END = 4'b0010;
    expect_out("l2_t2_s2", SEL_S2, 16'h0080);
    expect_out("l2_comb_s1", SEL_S1, 16'h0004);
    step();
    expect_out("l2_t3_s2", SEL_S2, 16'h0000);

    // lat[1]=3 (acts as 2), lat[2]=1, ignored bit 20 set
    step();
    FrameData = 32'h0010_001C; FrameStrobe = 1'b1; N2END = 8'h00;
    expect_out("cfg2_s2b", SEL_S2B, 16'h0000);
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0; N2END = 8'h02; N2MID = 8'h04;
    expect_out("l1_t0_s2b", SEL_S2B, 16'h0000);
    expect_out("l3_t0_s2", SEL_S2, 16'h0000);
    step();
    N2END = 8'h00; N2MID = 8'h00;
    expect_out("l1_t1_s2b", SEL_S2B, 16'h0040);
    expect_out("l3_t1_s2", SEL_S2, 16'h0000);
    step();
    expect_out("l1_t2_s2b", SEL_S2B, 16'h0000);
    expect_out("l3_t2_s2", SEL_S2, 16'h0020);

    // lat[3]=1 then switched to 0 mid-stream
    step();
    FrameData = 32'h0000_0040; FrameStrobe = 1'b1; N4END = 16'h0000;
    expect_out("s4_cfg", SEL_S4, 16'h0000);
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0; N4END = 16'h0001;
    expect_out("s4_l1_a", SEL_S4, 16'h0000);
    step();
    N4END = 16'h0002; FrameStrobe = 1'b1;
    expect_out("s4_l1_b", SEL_S4, 16'h8000);
    step();
    FrameStrobe = 1'b0; N4END = 16'h0004;
    expect_out("s4_l0_a", SEL_S4, 16'h2000);
    step();
    N4END = 16'h0008;
    expect_out("s4_l0_b", SEL_S4, 16'h1000);

`ifdef TERM_ACT_CNT_EN
    // Clear, single toggle, unused select
    step();
    act_sel = 3'd4; FrameData = 32'h8000_0000; FrameStrobe = 1'b1;
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0; NN4END = 16'h00F1;
    expect_out("cnt_clr0", SEL_ACT, 16'h0000);
    step();
    expect_out("cnt_one", SEL_ACT, 16'h0001);
    step();
    act_sel = 3'd6;
    expect_out("cnt_sel6", SEL_ACT, 16'h0000);
    step();
    act_sel = 3'd4;

    // Saturation after a long toggle run
    for (int i = 0; i < 70000; i++) begin
      step();
      NN4END = ~NN4END;
    end
    expect_out("cnt_sat", SEL_ACT, 16'hFFFF);
    step();
    expect_out("cnt_sat_hold", SEL_ACT, 16'hFFFF);
    step();
    NN4END = ~NN4END;
    expect_out("cnt_sat_hold2", SEL_ACT, 16'hFFFF);

    // Clear on the same cycle as a toggle wins over the increment
    step();
    NN4END = ~NN4END; FrameData = 32'h8000_0000; FrameStrobe = 1'b1;
    expect_out("cnt_pre_clr", SEL_ACT, 16'hFFFF);
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0;
    expect_out("cnt_after_clr", SEL_ACT, 16'h0000);
    step();
    act_sel = 3'd6;
    expect_out("cnt_clr_sel6", SEL_ACT, 16'h0000);
    act_sel = 3'd4;
`else
    step();
    act_sel = 3'd4; NN4END = ~NN4END;
    step();
    expect_out("act_tied0", SEL_ACT, 16'h0000);
    step();
    NN4END = ~NN4END; FrameData = 32'h8000_0000; FrameStrobe = 1'b1;
    expect_out("act_tied1", SEL_ACT, 16'h0000);
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0;
`endif

    // All lat=2, stream, then asynchronous reset mid-stream
    step();
    FrameData = 32'h0000_02AA; FrameStrobe = 1'b1; N1END = 4'b0000;
    step();
    FrameData = 32'h0; FrameStrobe = 1'b0; N1END = 4'b0001; NN4END = ~NN4END;
    expect_out("l2all_a", SEL_S1, 16'h0004);
    step();
    N1END = 4'b0011; NN4END = ~NN4END;
    expect_out("l2all_b", SEL_S1, 16'h0000);
    step();
    N1END = 4'b0100; NN4END = ~NN4END;
    expect_out("l2all_c", SEL_S1, 16'h0008);
    step();
    rst_n = 1'b0;
    expect_out("arst_s1", SEL_S1, 16'h0002);
    expect_out("arst_s4", SEL_S4, 16'h1000);
    expect_out("arst_act", SEL_ACT, 16'h0000);
    step();
    N2MID = 8'h10;
    expect_out("arst_s2", SEL_S2, 16'h0008);
    rst_n = 1'b1;

    @(negedge UserCLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
